bg_scene_ctrl: RTL and testbench
================================

// Module: bg_scene_ctrl
// PURPOSE
//  Scene sequencer for the background path: selects which full-screen picture the background
//  drawer shows (start, game, game-over) and a 4-bit brightness for fade-out/fade-in.
//  Scene and brightness change only on frame boundaries (no tearing). Sits beside the timing
//  generator; its outputs feed the background drawer's ROM select and RGB scaler.
// PARAMETERS
//  FADE_FRAMES  4   frames per brightness step (>=1)
//  FCNT_W       3   width of frame-step counter, FCNT_W >= clog2(FADE_FRAMES)
// PORTS
//  clk40MHz     in   1  pixel clock, all logic on posedge
//  rst          in   1  synchronous, active-high reset
//  vblnk        in   1  vertical blanking from timing generator
//  start_req    in   1  1-cycle pulse: player pressed start
//  over_req     in   1  1-cycle pulse: game logic signals game over
//  scene_sel    out  2  scene_t: SC_START=0, SC_GAME=1, SC_OVER=2 (3 never driven)
//  bright       out  4  brightness, 15=full, 0=black
//  busy         out  1  1 while a transition is in progress
//  scene_swap   out  1  1-cycle pulse in the cycle scene_sel changes
// BEHAVIOUR
//  Clock clk40MHz only; reset synchronous, active-high.
//  Reset: state=ST_SHOW, scene_sel=SC_START, bright=15, busy=0, scene_swap=0, pend=0, fcnt=0.
//  frame_tick: 1-cycle pulse, the cycle after vblnk is sampled 0->1 (prev-vblnk reg resets to 1,
//   so no tick directly after reset). Exactly one tick per frame.
//  step = frame_tick && fcnt==FADE_FRAMES-1; fcnt++ on every frame_tick in fade states, wraps to 0
//   on step; fcnt forced to 0 in ST_SHOW.
//  Request acceptance (ST_SHOW only; pulses in any other state are dropped, not queued):
//   scene SC_START + start_req -> target=SC_GAME; SC_GAME + over_req -> target=SC_OVER;
//   SC_OVER + start_req -> target=SC_START; other combos ignored. Accepted request sets pend.
//   start_req and over_req in same cycle: only the one valid for current scene counts.
//  FSM (states ST_SHOW, ST_FADE_OUT, ST_FADE_IN in shared enum):
//   ST_SHOW: pend && frame_tick -> ST_FADE_OUT, pend<=0, fcnt<=0. Request and tick in same
//    cycle: request latched, transition on next tick.
//   ST_FADE_OUT: on step: bright!=0 -> bright--; bright==0 -> scene_sel<=target, scene_swap=1,
//    -> ST_FADE_IN (bright stays 0). 15 decrements + 1 swap step = 16 steps.
//   ST_FADE_IN: on step: bright++; when bright becomes 15 -> ST_SHOW. 15 steps.
//   Total transition = 31*FADE_FRAMES frames. busy = (state != ST_SHOW), registered with state.
//  All outputs registered; latency vblnk rise -> output change = 2 cycles.
//  Reset mid-transition: immediate return to reset values (SC_START, full bright); target lost.
//  vblnk held high/low indefinitely: no ticks, FSM frozen; resumes on next rising edge.
// STRUCTURE
//  Shared package bg_pkg: scene_t enum (2 bit), bg_state_t enum, BRIGHT_MAX=4'd15.
//  Sub-module frame_tick_gen (vblnk rising-edge pulse generator); everything else in one
//  always_ff + always_comb next-state pair.
// TESTING (FADE_FRAMES=2, vblnk period ~ short synthetic frames)
//  1 Reset, 3 frames idle -> scene_sel=0, bright=15, busy=0, no scene_swap pulses.
//  2 start_req in SC_START -> busy on next tick; bright 15..0 stepping every 2 ticks; swap to
//    SC_GAME exactly 32 ticks after start; bright back to 15 and busy=0 at tick 62.
//  3 over_req in SC_START, start_req during fade-out -> both ignored; scene ends SC_GAME once.
//  4 SC_GAME + over_req -> SC_OVER; then start_req -> SC_START; one scene_swap pulse each.
//  5 rst asserted while bright=7 in ST_FADE_OUT -> next cycle scene_sel=0, bright=15, busy=0.
//  6 start_req coinciding with frame_tick in ST_SHOW -> fade starts on following tick, not this.

Source files
------------

// File: rtl/bg_pkg.sv
// ----------------------------------------------------------------------------
// bg_pkg
//   Types and helpers for the background scene sequencer.
//   - scene_t    : which full-screen picture the background drawer shows
//   - bg_state_t : sequencer state (steady picture, fading out, fading in)
//   - BRIGHT_MAX : full brightness code for the RGB scaler
//   - req_hit    : does a request pulse apply to the scene now on screen
//   - next_scene : the scene that an accepted request leads to
// ----------------------------------------------------------------------------
package bg_pkg;

    typedef enum logic [1:0] {
        SC_START = 2'd0,
        SC_GAME  = 2'd1,
        SC_OVER  = 2'd2
    } scene_t;

    typedef enum logic [1:0] {
        ST_SHOW     = 2'd0,
        ST_FADE_OUT = 2'd1,
        ST_FADE_IN  = 2'd2
    } bg_state_t;

    localparam logic [3:0] BRIGHT_MAX = 4'd15;

    // Only one request kind is meaningful per scene; when both pulses arrive
    // together the one that does not fit the current scene is ignored.
    function automatic logic req_hit(input scene_t scene,
                                     input logic   start_req,
                                     input logic   over_req);
        logic hit;
        hit = 1'b0;
        case (scene)
            SC_START: hit = start_req;
            SC_GAME:  hit = over_req;
            SC_OVER:  hit = start_req;
            default:  hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic scene_t next_scene(input scene_t scene);
        scene_t nxt;
        nxt = SC_START;
        case (scene)
            SC_START: nxt = SC_GAME;
            SC_GAME:  nxt = SC_OVER;
            SC_OVER:  nxt = SC_START;
            default:  nxt = SC_START;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/bg_scene_ctrl_frame_tick_gen.sv
// ----------------------------------------------------------------------------
// frame_tick_gen
//   Turns the vertical blanking level into one pulse per frame.
//   frame_tick is high for exactly one cycle, the cycle after vblnk is first
//   sampled high. The previous-sample register resets to 1, so a vblnk that is
//   already high (or low) at reset release produces no tick until the next
//   genuine rising edge.
// Ports
//   clk        in  1  clock, posedge
//   rst        in  1  synchronous, active-high reset
//   vblnk      in  1  vertical blanking level
//   frame_tick out 1  registered one-cycle pulse per vblnk rising edge
// ----------------------------------------------------------------------------
module frame_tick_gen (
    input  logic clk,
    input  logic rst,
    input  logic vblnk,
    output logic frame_tick
);

    logic vblnk_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_prev <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            vblnk_prev <= vblnk;
            frame_tick <= vblnk & ~vblnk_prev;
        end
    end

endmodule

// File: rtl/bg_scene_ctrl.sv
// ----------------------------------------------------------------------------
// bg_scene_ctrl
//   Scene sequencer for the background path. Chooses the full-screen picture
//   (start, game, game-over) and a 4-bit brightness used for fade-out/fade-in.
//   Everything changes only on frame ticks so the drawer never tears.
//
//   A transition fades brightness 15 -> 0 (15 steps), spends one more step to
//   swap the scene while black, then fades 0 -> 15 (15 steps). Each step lasts
//   FADE_FRAMES frames, so a transition takes 31*FADE_FRAMES frames.
//
//   Handshake: start_req / over_req are plain one-cycle pulses with no ready;
//   a pulse is taken only while the picture is steady (busy=0) and only if it
//   fits the scene on screen, otherwise it is dropped rather than queued.
//
// Parameters
//   FADE_FRAMES  frames per brightness step (>= 1)
//   FCNT_W       width of the frame-step counter
// Ports
//   clk40MHz   in   1  pixel clock, posedge
//   rst        in   1  synchronous, active-high reset
//   vblnk      in   1  vertical blanking from the timing generator
//   start_req  in   1  one-cycle pulse, player pressed start
//   over_req   in   1  one-cycle pulse, game over
//   scene_sel  out  2  scene_t code for the drawer ROM select
//   bright     out  4  brightness, 15 = full, 0 = black
//   busy       out  1  high while a transition is in progress
//   scene_swap out  1  one-cycle pulse in the cycle scene_sel changes
//   state_dbg  out  2  current bg_state_t, for observation only
// ----------------------------------------------------------------------------
module bg_scene_ctrl
    import bg_pkg::*;
#(
    parameter int FADE_FRAMES = 4,
    parameter int FCNT_W      = 3
) (
    input  logic       clk40MHz,
    input  logic       rst,
    input  logic       vblnk,
    input  logic       start_req,
    input  logic       over_req,
    output logic [1:0] scene_sel,
    output logic [3:0] bright,
    output logic       busy,
    output logic       scene_swap,
    output logic [1:0] state_dbg
);

    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FADE_FRAMES - 1);

    logic frame_tick;

    frame_tick_gen u_tick (
        .clk        (clk40MHz),
        .rst        (rst),
        .vblnk      (vblnk),
        .frame_tick (frame_tick)
    );

    // Registered state and outputs
    bg_state_t         state_q,  state_d;
    scene_t            scene_q,  scene_d;
    scene_t            target_q, target_d;
    logic              pend_q,   pend_d;
    logic [FCNT_W-1:0] fcnt_q,   fcnt_d;
    logic [3:0]        bright_q, bright_d;
    logic              busy_q,   busy_d;
    logic              swap_q,   swap_d;
    logic              step;

    always_comb begin
        state_d  = state_q;
        scene_d  = scene_q;
        target_d = target_q;
        pend_d   = pend_q;
        fcnt_d   = fcnt_q;
        bright_d = bright_q;
        swap_d   = 1'b0;
        step     = frame_tick && (fcnt_q == FCNT_LAST);

        case (state_q)
            ST_SHOW: begin
                fcnt_d = '0;
                // A pending request waits for a frame tick so the fade starts
                // on a frame boundary. A request arriving on the very tick is
                // only latched and starts the fade on the following tick.
                if (pend_q && frame_tick) begin
                    state_d = ST_FADE_OUT;
                    pend_d  = 1'b0;
                end else if (req_hit(scene_q, start_req, over_req)) begin
                    pend_d   = 1'b1;
                    target_d = next_scene(scene_q);
                end
            end

            ST_FADE_OUT: begin
                if (frame_tick) begin
                    fcnt_d = step ? '0 : fcnt_q + FCNT_W'(1);
                end
                if (step) begin
                    if (bright_q != 4'd0) begin
                        bright_d = bright_q - 4'd1;
                    end else begin
                        // Black screen: swap picture, brightness stays 0.
                        scene_d = target_q;
                        swap_d  = 1'b1;
                        state_d = ST_FADE_IN;
                    end
                end
            end

            ST_FADE_IN: begin
                if (frame_tick) begin
                    fcnt_d = step ? '0 : fcnt_q + FCNT_W'(1);
                end
                if (step) begin
                    bright_d = bright_q + 4'd1;
                    if (bright_q == BRIGHT_MAX - 4'd1) begin
                        state_d = ST_SHOW;
                    end
                end
            end

            default: begin
                state_d = ST_SHOW;
            end
        endcase

        // busy follows the next state so it is registered in step with state.
        busy_d = (state_d != ST_SHOW);
    end

    always_ff @(posedge clk40MHz) begin
        if (rst) begin
            state_q  <= ST_SHOW;
            scene_q  <= SC_START;
            target_q <= SC_START;
            pend_q   <= 1'b0;
            fcnt_q   <= '0;
            bright_q <= BRIGHT_MAX;
            busy_q   <= 1'b0;
            swap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            scene_q  <= scene_d;
            target_q <= target_d;
            pend_q   <= pend_d;
            fcnt_q   <= fcnt_d;
            bright_q <= bright_d;
            busy_q   <= busy_d;
            swap_q   <= swap_d;
        end
    end

    assign scene_sel  = scene_q;
    assign bright     = bright_q;
    assign busy       = busy_q;
    assign scene_swap = swap_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_bg_scene_ctrl.sv
// ----------------------------------------------------------------------------
// tb_bg_scene_ctrl
//   Drives synthetic short frames and request pulses into bg_scene_ctrl and
//   compares its outputs with a frame-level reference model: a transition is
//   tracked only as "frames elapsed since it started", from which brightness,
//   scene and phase follow by integer division.
// ----------------------------------------------------------------------------
module tb_bg_scene_ctrl;
    import bg_pkg::*;

    localparam int FF = 2;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       vblnk;
    logic       start_req;
    logic       over_req;
    logic [1:0] scene_sel;
    logic [3:0] bright;
    logic       busy;
    logic       scene_swap;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    bg_scene_ctrl #(.FADE_FRAMES(FF), .FCNT_W(3)) dut (
        .clk40MHz   (clk),
        .rst        (rst),
        .vblnk      (vblnk),
        .start_req  (start_req),
        .over_req   (over_req),
        .scene_sel  (scene_sel),
        .bright     (bright),
        .busy       (busy),
        .scene_swap (scene_swap),
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int total  = 0;
    int passed = 0;
    int swap_seen = 0;
    logic [1:0] exp_q[$];   // scenes expected at successive scene_swap pulses

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    always @(negedge clk) begin
        if (scene_swap) begin
            swap_seen++;
            if (exp_q.size() > 0) check("swap_scene", {30'd0, scene_sel}, {30'd0, exp_q.pop_front()});
        end
    end

    // ---------------- reference model ----------------
    int m_scene, m_target, m_k, m_swaps;
    bit m_busy, m_pend;

    task automatic model_reset();
        m_scene = 0; m_target = 0; m_k = 0;
        m_busy = 0; m_pend = 0;
        exp_q.delete();
    endtask

    task automatic model_req(input bit s, input bit o);
        if (!m_busy) begin
            if (m_scene == 0 && s)      begin m_pend = 1; m_target = 1; end
            else if (m_scene == 1 && o) begin m_pend = 1; m_target = 2; end
            else if (m_scene == 2 && s) begin m_pend = 1; m_target = 0; end
        end
    endtask

    task automatic model_tick();
        if (!m_busy) begin
            if (m_pend) begin m_busy = 1; m_k = 0; m_pend = 0; end
        end else begin
            m_k++;
            if (m_k == 16 * FF) begin
                m_scene = m_target;
                m_swaps++;
                exp_q.push_back(2'(m_target));
            end
            if (m_k == 31 * FF) m_busy = 0;
        end
    endtask

    function automatic int m_bright();
        int s;
        if (!m_busy) return 15;
        s = m_k / FF;
        if (s <= 15) return 15 - s;
        return s - 16;
    endfunction

    function automatic int m_state();
        if (!m_busy) return int'(ST_SHOW);
        if (m_k < 16 * FF) return int'(ST_FADE_OUT);
        return int'(ST_FADE_IN);
    endfunction

    task automatic check_outputs();
        check("scene_sel", {30'd0, scene_sel}, m_scene);
        check("bright", {28'd0, bright}, m_bright());
        check("busy", {31'd0, busy}, {31'd0, m_busy});
        check("state", {30'd0, state_dbg}, m_state());
        check("swap_count", swap_seen, m_swaps);
    endtask

    // ---------------- driver tasks ----------------
    // One frame: optional request pulse early in the low phase, then a
    // rising vblnk edge; outputs are checked once the tick has settled.
    task automatic frame(input bit s, input bit o);
        int lo, hi;
        lo = $urandom_range(3, 6);
        hi = $urandom_range(4, 6);
        @(negedge clk);
        vblnk = 0; start_req = s; over_req = o;
        model_req(s, o);
        @(negedge clk);
        start_req = 0; over_req = 0;
        repeat (lo) @(negedge clk);
        vblnk = 1;
        model_tick();
        repeat (hi) @(negedge clk);
        check_outputs();
    endtask

    // Frame whose request pulse lands in the same cycle as frame_tick.
    task automatic frame_on_tick(input bit s, input bit o);
        bit pre_busy;
        @(negedge clk);
        vblnk = 0;
        repeat ($urandom_range(3, 6)) @(negedge clk);
        vblnk = 1;
        @(negedge clk);              // tick is high during this cycle
        start_req = s; over_req = o;
        pre_busy = m_busy;
        model_tick();
        if (!pre_busy && !m_busy) model_req(s, o);
        @(negedge clk);
        start_req = 0; over_req = 0;
        repeat (4) @(negedge clk);
        check_outputs();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        model_reset();
        check("rst_scene", {30'd0, scene_sel}, 0);
        check("rst_bright", {28'd0, bright}, 15);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_swap", {31'd0, scene_swap}, 0);
        rst = 0;
    endtask

    task automatic run_until_idle();
        for (int i = 0; i < 80 && m_busy; i++) frame(0, 0);
        check("idle_reached", {31'd0, busy}, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1; vblnk = 0; start_req = 0; over_req = 0;
        m_swaps = 0;
        model_reset();
        repeat (3) @(negedge clk);
        pulse_reset();

        // idle frames
        repeat (3) frame(0, 0);

        // start -> game, full transition
        frame(1, 0);
        run_until_idle();
        check("scene_after_start", {30'd0, scene_sel}, 1);

        // game -> over -> start
        frame(0, 1);
        run_until_idle();
        frame(1, 0);
        run_until_idle();
        check("scene_back_start", {30'd0, scene_sel}, 0);

        // wrong request ignored, then requests during fade dropped
        frame(0, 1);
        frame(1, 0);
        for (int i = 0; i < 10; i++) frame(1, i[0]);
        run_until_idle();

        // request on the tick itself (now in SC_GAME)
        frame_on_tick(0, 1);
        frame(0, 0);
        run_until_idle();

        // reset mid fade-out at bright 7
        frame(1, 0);
        for (int i = 0; i < 40 && m_bright() != 7; i++) frame(0, 0);
        check("reached_bright7", {28'd0, bright}, 7);
        pulse_reset();
        repeat (2) frame(0, 0);

        // randomized frames
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 149) == 0) pulse_reset();
            else if ($urandom_range(0, 9) == 0)
                frame_on_tick($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            else
                frame($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
        end
        run_until_idle();

        check("exp_q_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
